// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer
// Bit-period timing for a serial receiver that recovers its clock from line
// transitions. A phase counter runs once per bit period and is re-aligned on
// every detected edge. Each bit is sampled at a fixed phase. Stuffed bits are
// dropped and the accepted bits are counted into words. A sticky flag is set
// when no edge has been seen for too many bit periods.
//
// Parameters
//   CLKS_PER_BIT  : clock cycles per serial bit period (4..64)
//   SAMPLE_PHASE  : phase count at which a bit is sampled (1..CLKS_PER_BIT-1)
//   BITS_PER_WORD : accepted bits per received word (2..32)
//   MAX_IDLE_BITS : edge-free bit periods before sync_err is raised (1..255)
//
// Ports
//   clk           : in  - single clock, rising edge
//   n_rst         : in  - synchronous active-low reset
//   d_edge        : in  - line transition detected this cycle
//   rcving        : in  - packet reception active
//   skip_bit      : in  - current bit is a stuffed bit, discard it
//   shift_enable  : out - one-cycle strobe, shift in the sampled bit
//   byte_received : out - one-cycle strobe, the cycle after a word's last bit
//   bit_index     : out - bits accepted so far in the current word
//   stuff_drop    : out - one-cycle strobe, a sample was discarded
//   sync_err      : out - sticky loss-of-sync flag, cleared when rcving drops
// ---------------------------------------------------------------------------
module rx_bit_timer #(
   parameter int CLKS_PER_BIT  = 8,
   parameter int SAMPLE_PHASE  = 4,
   parameter int BITS_PER_WORD = 8,
   parameter int MAX_IDLE_BITS = 7
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             d_edge,
   input  logic                             rcving,
   input  logic                             skip_bit,
   output logic                             shift_enable,
   output logic                             byte_received,
   output logic [$clog2(BITS_PER_WORD)-1:0] bit_index,
   output logic                             stuff_drop,
   output logic                             sync_err
);

   localparam int PH_W   = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(BITS_PER_WORD);
   localparam int IDLE_W = $clog2(MAX_IDLE_BITS + 1);

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
   localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_PHASE);
   localparam logic [PH_W-1:0]   PH_RESYNC = PH_W'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BITS_PER_WORD - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(MAX_IDLE_BITS);

   logic [PH_W-1:0]   r_ph;
   logic [PH_W-1:0]   w_ph_next;
   logic [IDX_W-1:0]  r_bit_index;
   logic [IDX_W-1:0]  w_bit_index_next;
   logic [IDLE_W-1:0] r_idle;
   logic [IDLE_W-1:0] w_idle_next;
   logic              r_byte_received;
   logic              w_byte_received_next;
   logic              r_sync_err;
   logic              w_sync_err_next;

   logic              w_sample;
   logic              w_shift;
   logic              w_last_bit;

   // The sample decision uses the registered phase, so an edge arriving in
   // the sample cycle itself re-aligns the next bit but still lets this one
   // be taken.
   assign w_sample   = rcving && (r_ph == PH_SAMPLE);
   assign w_shift    = w_sample && !skip_bit;
   assign w_last_bit = (r_bit_index == IDX_LAST);

   always_comb begin
      // Defaults: everything returns to its idle value while not receiving.
      w_ph_next            = '0;
      w_bit_index_next     = '0;
      w_idle_next          = '0;
      w_byte_received_next = 1'b0;
      w_sync_err_next      = 1'b0;

      if (rcving) begin
         // The edge cycle counts as phase 0, so the following cycle is 1.
         if (d_edge) begin
            w_ph_next = PH_RESYNC;
         end else if (r_ph == PH_LAST) begin
            w_ph_next = '0;
         end else begin
            w_ph_next = r_ph + 1'b1;
         end

         w_bit_index_next = r_bit_index;
         if (w_shift) begin
            if (w_last_bit) begin
               w_bit_index_next     = '0;
               w_byte_received_next = 1'b1;
            end else begin
               w_bit_index_next = r_bit_index + 1'b1;
            end
         end

         // Counts whole bit periods (phase wrap) since the last edge and
         // saturates so that it cannot roll back under the threshold.
         w_idle_next = r_idle;
         if (d_edge) begin
            w_idle_next = '0;
         end else if ((r_ph == PH_LAST) && (r_idle != IDLE_MAX)) begin
            w_idle_next = r_idle + 1'b1;
         end

         // Raised in the same cycle the counter shows the threshold value.
         // A later edge does not clear it. Only rcving low or reset does.
         w_sync_err_next = r_sync_err || (w_idle_next == IDLE_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_ph            <= '0;
         r_bit_index     <= '0;
         r_idle          <= '0;
         r_byte_received <= 1'b0;
         r_sync_err      <= 1'b0;
      end else begin
         r_ph            <= w_ph_next;
         r_bit_index     <= w_bit_index_next;
         r_idle          <= w_idle_next;
         r_byte_received <= w_byte_received_next;
         r_sync_err      <= w_sync_err_next;
      end
   end

   assign shift_enable  = w_shift;
   assign stuff_drop    = w_sample && skip_bit;
   assign byte_received = r_byte_received;
   assign bit_index     = r_bit_index;
   assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_rx_bit_timer
// Self-checking bench for rx_bit_timer. One instance uses the default
// parameters. A second instance uses CLKS_PER_BIT=5, SAMPLE_PHASE=2 and
// BITS_PER_WORD=4.
// Each test pushes the cycle numbers of the expected strobes into queues. A
// negedge monitor pops an entry whenever a strobe appears, and fails if the
// strobe is not the next one expected. Each task checks state inline and
// confirms at its end that no expected strobe is left.
// Cycle c of a test begins at the c-th rising edge after the test starts.
// Inputs change 1 time unit after that edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_rx_bit_timer;

   logic       clk = 1'b0;
   logic       n_rst;

   logic       d_edge, rcving, skip_bit;
   logic       shift_enable, byte_received, stuff_drop, sync_err;
   logic [2:0] bit_index;

   logic       d_edge1, rcving1, skip_bit1;
   logic       shift_enable1, byte_received1, stuff_drop1, sync_err1;
   logic [1:0] bit_index1;

   int checks   = 0;
   int failures = 0;
   int cyc      = -1;
   bit mon_on   = 1'b0;

   int q_se[$];
   int q_br[$];
   int q_sd[$];
   int q1_se[$];
   int q1_br[$];

   always #5 clk = ~clk;

   rx_bit_timer dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .d_edge        (d_edge),
      .rcving        (rcving),
      .skip_bit      (skip_bit),
      .shift_enable  (shift_enable),
      .byte_received (byte_received),
      .bit_index     (bit_index),
      .stuff_drop    (stuff_drop),
      .sync_err      (sync_err)
   );

   rx_bit_timer #(
      .CLKS_PER_BIT  (5),
      .SAMPLE_PHASE  (2),
      .BITS_PER_WORD (4),
      .MAX_IDLE_BITS (7)
   ) dut_small (
      .clk           (clk),
      .n_rst         (n_rst),
      .d_edge        (d_edge1),
      .rcving        (rcving1),
      .skip_bit      (skip_bit1),
      .shift_enable  (shift_enable1),
      .byte_received (byte_received1),
      .bit_index     (bit_index1),
      .stuff_drop    (stuff_drop1),
      .sync_err      (sync_err1)
   );

   // Scoreboard: every observed strobe must match the head of its queue.
   always @(negedge clk) begin
      if (mon_on) begin
         if (shift_enable) begin
            checks++;
            if (q_se.size() != 0 && q_se[0] == cyc) void'(q_se.pop_front());
            else begin
               failures++;
               $display("FAIL shift_enable: strobe at cycle %0d, required cycle %0d",
                        cyc, (q_se.size() != 0) ? q_se[0] : -1);
            end
         end
         if (byte_received) begin
            checks++;
            if (q_br.size() != 0 && q_br[0] == cyc) void'(q_br.pop_front());
            else begin
               failures++;
               $display("FAIL byte_received: strobe at cycle %0d, required cycle %0d",
                        cyc, (q_br.size() != 0) ? q_br[0] : -1);
            end
         end
         if (stuff_drop) begin
            checks++;
            if (q_sd.size() != 0 && q_sd[0] == cyc) void'(q_sd.pop_front());
            else begin
               failures++;
               $display("FAIL stuff_drop: strobe at cycle %0d, required cycle %0d",
                        cyc, (q_sd.size() != 0) ? q_sd[0] : -1);
            end
         end
         if (shift_enable1) begin
            checks++;
            if (q1_se.size() != 0 && q1_se[0] == cyc) void'(q1_se.pop_front());
            else begin
               failures++;
               $display("FAIL small_shift_enable: strobe at cycle %0d, required cycle %0d",
                        cyc, (q1_se.size() != 0) ? q1_se[0] : -1);
            end
         end
         if (byte_received1) begin
            checks++;
            if (q1_br.size() != 0 && q1_br[0] == cyc) void'(q1_br.pop_front());
            else begin
               failures++;
               $display("FAIL small_byte_received: strobe at cycle %0d, required cycle %0d",
                        cyc, (q1_br.size() != 0) ? q1_br[0] : -1);
            end
         end
         if (stuff_drop1) begin
            checks++;
            failures++;
            $display("FAIL small_stuff_drop: strobe at cycle %0d, required none", cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with rcving low on both instances, clearing per-word state.
   task automatic idle_gap();
      cyc      = -1;
      rcving   = 1'b0;
      d_edge   = 1'b0;
      skip_bit = 1'b0;
      rcving1  = 1'b0;
      d_edge1  = 1'b0;
      tick();
   endtask

   task automatic clear_queues();
      q_se.delete();
      q_br.delete();
      q_sd.delete();
      q1_se.delete();
      q1_br.delete();
   endtask

   task automatic test_reset();
      n_rst     = 1'b0;
      rcving    = 1'b1;
      d_edge    = 1'b1;
      skip_bit  = 1'b0;
      rcving1   = 1'b1;
      d_edge1   = 1'b1;
      skip_bit1 = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({shift_enable, byte_received, stuff_drop, sync_err, bit_index} !== 7'd0) begin
         failures++;
         $display("FAIL reset_outputs: se=%b br=%b sd=%b err=%b idx=%0d, required all 0",
                  shift_enable, byte_received, stuff_drop, sync_err, bit_index);
      end
      checks++;
      if ({shift_enable1, byte_received1, stuff_drop1, sync_err1, bit_index1} !== 6'd0) begin
         failures++;
         $display("FAIL reset_outputs_small: se=%b br=%b sd=%b err=%b idx=%0d, required all 0",
                  shift_enable1, byte_received1, stuff_drop1, sync_err1, bit_index1);
      end
      n_rst   = 1'b1;
      rcving  = 1'b0;
      d_edge  = 1'b0;
      rcving1 = 1'b0;
      d_edge1 = 1'b0;
      tick();
      mon_on = 1'b1;
   endtask

   task automatic test_defaults();
      clear_queues();
      for (int k = 0; k < 8; k++) q_se.push_back(4 + 8 * k);
      q_br.push_back(61);
      for (int c = 0; c < 64; c++) begin
         cyc    = c;
         rcving = 1'b1;
         @(negedge clk);
         if (c == 60) begin
            checks++;
            if (bit_index !== 3'd7) begin
               failures++;
               $display("FAIL defaults_index_last: bit_index=%0d, required 7", bit_index);
            end
         end
         if (c == 61) begin
            checks++;
            if (bit_index !== 3'd0) begin
               failures++;
               $display("FAIL defaults_index_wrap: bit_index=%0d, required 0", bit_index);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q_se.size() + q_br.size() != 0) begin
         failures++;
         $display("FAIL defaults_missing: %0d strobes outstanding, required 0",
                  q_se.size() + q_br.size());
      end
   endtask

   task automatic test_resync();
      clear_queues();
      q_se = '{4, 14, 22, 30, 38};
      for (int c = 0; c < 40; c++) begin
         cyc    = c;
         rcving = 1'b1;
         d_edge = (c == 10);
         @(negedge clk);
         if (c == 14) begin
            checks++;
            if (bit_index !== 3'd1) begin
               failures++;
               $display("FAIL resync_index: bit_index=%0d, required 1", bit_index);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q_se.size() != 0) begin
         failures++;
         $display("FAIL resync_missing: %0d strobes outstanding, required 0", q_se.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      // Edges 10..13 hold ph at 1 so the next sample is at 17. The edge at
      // 25 coincides with a sample that must still fire, and moves the next
      // sample to 29.
      q_se = '{4, 17, 25, 29};
      for (int c = 0; c < 35; c++) begin
         cyc    = c;
         rcving = 1'b1;
         d_edge = (c >= 10 && c <= 13) || (c == 25);
         @(negedge clk);
         if (c == 29) begin
            checks++;
            if (bit_index !== 3'd3) begin
               failures++;
               $display("FAIL b2b_index: bit_index=%0d, required 3", bit_index);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q_se.size() != 0) begin
         failures++;
         $display("FAIL b2b_missing: %0d strobes outstanding, required 0", q_se.size());
      end
   endtask

   task automatic test_skip();
      clear_queues();
      q_se = '{4, 12, 28, 36, 44, 52, 60, 68};
      q_br.push_back(69);
      q_sd.push_back(20);
      for (int c = 0; c < 75; c++) begin
         cyc      = c;
         rcving   = 1'b1;
         skip_bit = (c == 20);
         @(negedge clk);
         if (c == 20 || c == 21) begin
            checks++;
            if (bit_index !== 3'd2) begin
               failures++;
               $display("FAIL skip_index_c%0d: bit_index=%0d, required 2", c, bit_index);
            end
         end
         if (c == 69) begin
            checks++;
            if (bit_index !== 3'd0) begin
               failures++;
               $display("FAIL skip_index_wrap: bit_index=%0d, required 0", bit_index);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q_se.size() + q_br.size() + q_sd.size() != 0) begin
         failures++;
         $display("FAIL skip_missing: %0d strobes outstanding, required 0",
                  q_se.size() + q_br.size() + q_sd.size());
      end
   endtask

   task automatic test_sync_err();
      logic exp_err;
      clear_queues();
      q_se = '{4, 12, 20, 28, 36, 44, 52};
      for (int c = 0; c < 62; c++) begin
         cyc    = c;
         rcving = (c < 60);
         d_edge = (c == 58);
         @(negedge clk);
         // The idle count reaches 7 in cycle 56. The flag holds through the
         // edge at 58 and clears one cycle after rcving falls at 60.
         if (c == 55 || c == 56 || c == 59 || c == 60 || c == 61) begin
            exp_err = (c >= 56 && c <= 60);
            checks++;
            if (sync_err !== exp_err) begin
               failures++;
               $display("FAIL sync_err_c%0d: sync_err=%b, required %b", c, sync_err, exp_err);
            end
         end
         if (c == 61) begin
            checks++;
            if (bit_index !== 3'd0) begin
               failures++;
               $display("FAIL sync_index_clear: bit_index=%0d, required 0", bit_index);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q_se.size() != 0) begin
         failures++;
         $display("FAIL sync_missing: %0d strobes outstanding, required 0", q_se.size());
      end
   endtask

   task automatic test_reset_midword();
      clear_queues();
      q_se = '{4, 12, 20, 28, 36};
      for (int k = 0; k < 8; k++) q_se.push_back(45 + 8 * k);
      q_br.push_back(102);
      for (int c = 0; c < 104; c++) begin
         cyc    = c;
         rcving = 1'b1;
         n_rst  = !(c == 40);
         @(negedge clk);
         if (c == 40) begin
            checks++;
            if (bit_index !== 3'd5) begin
               failures++;
               $display("FAIL midreset_before: bit_index=%0d, required 5", bit_index);
            end
         end
         if (c == 41) begin
            checks++;
            if ({shift_enable, byte_received, stuff_drop, sync_err, bit_index} !== 7'd0) begin
               failures++;
               $display("FAIL midreset_after: se=%b br=%b sd=%b err=%b idx=%0d, required all 0",
                        shift_enable, byte_received, stuff_drop, sync_err, bit_index);
            end
         end
         tick();
      end
      n_rst = 1'b1;
      idle_gap();
      checks++;
      if (q_se.size() + q_br.size() != 0) begin
         failures++;
         $display("FAIL midreset_missing: %0d strobes outstanding, required 0",
                  q_se.size() + q_br.size());
      end
   endtask

   task automatic test_small_config();
      clear_queues();
      q1_se = '{2, 7, 12, 17};
      q1_br.push_back(18);
      for (int c = 0; c < 22; c++) begin
         cyc     = c;
         rcving1 = 1'b1;
         @(negedge clk);
         if (c == 17) begin
            checks++;
            if (bit_index1 !== 2'd3) begin
               failures++;
               $display("FAIL small_index_last: bit_index=%0d, required 3", bit_index1);
            end
         end
         if (c == 18) begin
            checks++;
            if (bit_index1 !== 2'd0) begin
               failures++;
               $display("FAIL small_index_wrap: bit_index=%0d, required 0", bit_index1);
            end
         end
         tick();
      end
      idle_gap();
      checks++;
      if (q1_se.size() + q1_br.size() != 0) begin
         failures++;
         $display("FAIL small_missing: %0d strobes outstanding, required 0",
                  q1_se.size() + q1_br.size());
      end
   endtask

   initial begin
      n_rst     = 1'b0;
      d_edge    = 1'b0;
      rcving    = 1'b0;
      skip_bit  = 1'b0;
      d_edge1   = 1'b0;
      rcving1   = 1'b0;
      skip_bit1 = 1'b0;
      test_reset();
      test_defaults();
      test_resync();
      test_back_to_back();
      test_skip();
      test_sync_err();
      test_reset_midword();
      test_small_config();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_bit_timer.md
RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per serial bit period (legal range 4..64).
REQ-002 SHALL have parameter SAMPLE_PHASE, default 4, phase count at which a bit is sampled (legal range 1..CLKS_PER_BIT-1).
REQ-003 SHALL have parameter BITS_PER_WORD, default 8, accepted bits per received word (legal range 2..32).
REQ-004 SHALL have parameter MAX_IDLE_BITS, default 7, bit periods without d_edge before sync error (legal range 1..255).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk is a 1-bit input, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit: synchronous active-low reset, sampled only on rising clk.
REQ-007 SHALL have port d_edge, input, 1 bit: line transition detected this cycle.
REQ-008 SHALL have port rcving, input, 1 bit: packet reception active.
REQ-009 SHALL have port skip_bit, input, 1 bit: current bit is a stuffed bit and is to be discarded.
REQ-010 SHALL have port shift_enable, output, 1 bit: one-cycle strobe to shift in the sampled bit.
REQ-011 SHALL have port byte_received, output, 1 bit: one-cycle strobe after the last bit of a word.
REQ-012 SHALL have port bit_index, output, $clog2(BITS_PER_WORD) bits: count of bits accepted in the current word.
REQ-013 SHALL have port stuff_drop, output, 1 bit: one-cycle strobe when a sample is discarded.
REQ-014 SHALL have port sync_err, output, 1 bit: sticky loss-of-sync flag.

Function
REQ-015 SHALL keep phase counter ph, width $clog2(CLKS_PER_BIT); while rcving=0, ph<=0, bit_index<=0, idle counter<=0, sync_err<=0.
REQ-016 SHALL update ph while rcving=1 as follows: d_edge=1 -> ph<=1 (resync; edge cycle counts as phase 0); else ph==CLKS_PER_BIT-1 -> ph<=0; else ph<=ph+1.
REQ-017 SHALL define the sample cycle as rcving=1 and ph==SAMPLE_PHASE, using the registered ph; a d_edge in the same cycle does not suppress that sample.
REQ-018 SHALL drive shift_enable combinationally high in a sample cycle with skip_bit=0, and low otherwise.
REQ-019 SHALL drive stuff_drop combinationally high in a sample cycle with skip_bit=1; shift_enable then stays 0 and bit_index does not change.
REQ-020 SHALL increment bit_index on each shift_enable, and on shift_enable with bit_index==BITS_PER_WORD-1 SHALL wrap bit_index to 0 and set byte_received high for exactly the next cycle.
REQ-021 SHALL count completed bit periods (ph wrapping to 0) since the last d_edge in an idle counter of width $clog2(MAX_IDLE_BITS+1), cleared by d_edge and saturating at MAX_IDLE_BITS.
REQ-022 SHALL set sync_err on the cycle the idle counter reaches MAX_IDLE_BITS, and SHALL hold it until rcving=0 or reset; sampling continues while sync_err=1.
REQ-023 SHALL clear ph, bit_index, the idle counter and sync_err on the next edge when rcving falls mid-word; byte_received is not generated for a partial word.
REQ-024 SHALL treat back-to-back d_edge cycles as repeated resyncs: ph stays 1 and no sample occurs until ph reaches SAMPLE_PHASE.

Reset
REQ-025 SHALL, with n_rst=0 at a rising clk edge, set ph=0, bit_index=0, idle counter=0, byte_received=0 and sync_err=0; shift_enable and stuff_drop are then 0.
REQ-026 SHALL give reset priority over all other inputs, including mid-word, and SHALL resume with the REQ-016 rules on the first edge with n_rst=1.

Verification
REQ-027 Bench SHALL cover: defaults, rcving rises at cycle 0 with no edges -> shift_enable in cycles 4, 12, 20, ... and byte_received in cycle 61 (one cycle after the 8th strobe).
REQ-028 Bench SHALL cover: d_edge in cycle 10 -> ph=1 in cycle 11 and the next shift_enable in cycle 14, then every 8 cycles.
REQ-029 Bench SHALL cover: skip_bit=1 on the 3rd sample -> stuff_drop pulses, no shift_enable, bit_index stays 2, and byte_received is delayed by one bit period (8 cycles).
REQ-030 Bench SHALL cover: rcving=1 with no d_edge for 7 bit periods -> sync_err rises when the idle counter reaches 7 and clears one cycle after rcving=0.
REQ-031 Bench SHALL cover: n_rst=0 for one cycle at bit_index=5 -> all outputs 0 and the next word's byte_received arrives only after 8 fresh shift_enable strobes.
REQ-032 Bench SHALL cover: CLKS_PER_BIT=5, SAMPLE_PHASE=2, BITS_PER_WORD=4 -> shift_enable in cycles 2, 7, 12, 17 and byte_received in cycle 18.
